// File: rtl/asrv32_pkg.sv
// Shared ASRV32 definitions: load funct3 encodings and the writeback state encoding.
package asrv32_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/asrv32_load_align.sv
// Combinational load formatter: picks the byte/halfword out of a little-endian word and extends it.
module asrv32_load_align
    import asrv32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lsb,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lsb)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // Halfword loads are aligned upstream, so only lsb[1] matters here.
        half_sel = lsb[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'd0, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/asrv32_writeback.sv
// ASRV32 writeback stage: retires one instruction per handshake, waits on load responses
// and issues a registered single-cycle register-file write.
module asrv32_writeback
    import asrv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_wr_rd,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_result,
    input  logic        i_is_load,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lsb,
    input  logic        i_rdata_valid,
    input  logic [31:0] i_rdata,
    output logic        o_ce_wr,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_load_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    wb_state_t        state, state_nxt;
    logic             accept;
    logic             cnt_hit;
    logic [CNT_W-1:0] cnt_p1;
    logic             wr_rd_p1;
    logic [4:0]       rd_p1;
    logic [2:0]       funct3_p1;
    logic [1:0]       lsb_p1;
    logic [31:0]      load_data;

    assign accept  = i_valid && o_ready;
    assign cnt_hit = (cnt_p1 == CNT_LAST);

    asrv32_load_align u_align (
        .rdata  (i_rdata),
        .funct3 (funct3_p1),
        .lsb    (lsb_p1),
        .data   (load_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept && i_is_load) state_nxt = WAIT_LOAD;
            WAIT_LOAD: if (i_rdata_valid || cnt_hit) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
    end

    // p1: pending-load context captured at accept
    always_ff @(posedge i_clk) begin
        if (accept && i_is_load) begin
            wr_rd_p1  <= i_wr_rd;
            rd_p1     <= i_rd_addr;
            funct3_p1 <= i_funct3;
            lsb_p1    <= i_addr_lsb;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_p1 <= '0;
        end else if (accept && i_is_load) begin
            cnt_p1 <= '0;
        end else if (state == WAIT_LOAD && !i_rdata_valid) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    // Register-file write port; a response coinciding with the limit takes priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ce_wr        <= 1'b0;
            o_rd_addr      <= '0;
            o_rd_data      <= '0;
            o_load_timeout <= 1'b0;
        end else begin
            o_ce_wr        <= 1'b0;
            o_load_timeout <= 1'b0;
            if (accept && !i_is_load) begin
                o_ce_wr   <= i_wr_rd && (i_rd_addr != 5'd0);
                o_rd_addr <= i_rd_addr;
                o_rd_data <= i_result;
            end else if (state == WAIT_LOAD) begin
                if (i_rdata_valid) begin
                    o_ce_wr   <= wr_rd_p1 && (rd_p1 != 5'd0);
                    o_rd_addr <= rd_p1;
                    o_rd_data <= load_data;
                end else if (cnt_hit) begin
                    o_load_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_asrv32_writeback.sv
// Bench for asrv32_writeback: two instances (default and 3-cycle timeout) against a transaction model.
module tb_asrv32_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, wr_rd = 1'b0, is_load = 1'b0, rdata_valid = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] result = '0, rdata = '0;
    logic [2:0]  f3 = '0;
    logic [1:0]  lsb = '0;

    logic [1:0]       ready_v, ce_v, to_v;
    logic [1:0][4:0]  addr_v;
    logic [1:0][31:0] data_v;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    asrv32_writeback dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready_v[0]),
        .i_wr_rd(wr_rd), .i_rd_addr(rd), .i_result(result), .i_is_load(is_load),
        .i_funct3(f3), .i_addr_lsb(lsb), .i_rdata_valid(rdata_valid), .i_rdata(rdata),
        .o_ce_wr(ce_v[0]), .o_rd_addr(addr_v[0]), .o_rd_data(data_v[0]),
        .o_load_timeout(to_v[0])
    );

    asrv32_writeback #(.TIMEOUT_CYCLES(3)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready_v[1]),
        .i_wr_rd(wr_rd), .i_rd_addr(rd), .i_result(result), .i_is_load(is_load),
        .i_funct3(f3), .i_addr_lsb(lsb), .i_rdata_valid(rdata_valid), .i_rdata(rdata),
        .o_ce_wr(ce_v[1]), .o_rd_addr(addr_v[1]), .o_rd_data(data_v[1]),
        .o_load_timeout(to_v[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] ft, input logic [1:0] ls);
        logic [31:0] sh;
        case (ft)
            3'b000: begin sh = w >> (8 * int'(ls));      return {{24{sh[7]}}, sh[7:0]}; end
            3'b100: begin sh = w >> (8 * int'(ls));      return {24'd0, sh[7:0]}; end
            3'b001: begin sh = w >> (16 * int'(ls[1]));  return {{16{sh[15]}}, sh[15:0]}; end
            3'b101: begin sh = w >> (16 * int'(ls[1]));  return {16'd0, sh[15:0]}; end
            default: return w;
        endcase
    endfunction

    // Transaction model: a pending load remembers its accept cycle and expires TIMEOUT cycles later.
    logic        pend[2], p_wr[2];
    logic [4:0]  p_rd[2];
    logic [2:0]  p_f3[2];
    logic [1:0]  p_lsb[2];
    int          t_acc[2], tmo[2];
    logic        e_ce[2], e_to[2], e_chk[2];
    logic [4:0]  e_addr[2];
    logic [31:0] e_data[2];

    initial begin
        tmo[0] = 255;
        tmo[1] = 3;
        for (int u = 0; u < 2; u++) begin
            pend[u] = 1'b0; p_wr[u] = 1'b0; p_rd[u] = '0; p_f3[u] = '0; p_lsb[u] = '0;
            t_acc[u] = 0; e_ce[u] = 1'b0; e_to[u] = 1'b0; e_chk[u] = 1'b0;
            e_addr[u] = '0; e_data[u] = '0;
        end
        forever begin
            @(posedge clk);
            for (int u = 0; u < 2; u++) begin
                e_ce[u] = 1'b0; e_to[u] = 1'b0; e_chk[u] = 1'b0;
                if (!rst_n) begin
                    pend[u] = 1'b0; e_addr[u] = '0; e_data[u] = '0; e_chk[u] = 1'b1;
                end else if (!pend[u]) begin
                    if (valid && is_load) begin
                        pend[u] = 1'b1; p_wr[u] = wr_rd; p_rd[u] = rd;
                        p_f3[u] = f3; p_lsb[u] = lsb; t_acc[u] = cyc;
                    end else if (valid) begin
                        e_ce[u] = wr_rd && (rd != 5'd0); e_addr[u] = rd;
                        e_data[u] = result; e_chk[u] = 1'b1;
                    end
                end else if (rdata_valid) begin
                    pend[u] = 1'b0; e_ce[u] = p_wr[u] && (p_rd[u] != 5'd0);
                    e_addr[u] = p_rd[u]; e_data[u] = fmt(rdata, p_f3[u], p_lsb[u]); e_chk[u] = 1'b1;
                end else if (cyc - t_acc[u] >= tmo[u]) begin
                    pend[u] = 1'b0; e_to[u] = 1'b1;
                end
            end
            cyc++;
            #1;
            for (int u = 0; u < 2; u++) begin
                check($sformatf("u%0d ready", u), 32'(ready_v[u]), 32'(!pend[u]));
                check($sformatf("u%0d ce_wr", u), 32'(ce_v[u]), 32'(e_ce[u]));
                check($sformatf("u%0d timeout", u), 32'(to_v[u]), 32'(e_to[u]));
                if (e_chk[u]) begin
                    check($sformatf("u%0d rd_addr", u), 32'(addr_v[u]), 32'(e_addr[u]));
                    check($sformatf("u%0d rd_data", u), data_v[u], e_data[u]);
                end
            end
        end
    end

    task automatic do_load(input logic [2:0] ft, input logic [1:0] ls, input logic [31:0] exp);
        valid = 1'b1; is_load = 1'b1; wr_rd = 1'b1; rd = 5'd3; f3 = ft; lsb = ls;
        @(negedge clk);
        valid = 1'b0; is_load = 1'b0;
        check("load ready low", 32'(ready_v[0]), 32'd0);
        rdata_valid = 1'b1; rdata = 32'h80FF7F01;
        @(negedge clk);
        rdata_valid = 1'b0;
        check("load ce_wr", 32'(ce_v[0]), 32'd1);
        check("load rd_addr", 32'(addr_v[0]), 32'd3);
        check($sformatf("load f3=%0d lsb=%0d data", ft, ls), data_v[0], exp);
        check("load ready back", 32'(ready_v[0]), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset ready", 32'(ready_v), 32'h3);
        check("reset ce_wr", 32'(ce_v), 32'h0);
        check("reset timeout", 32'(to_v), 32'h0);
        check("reset rd_addr", 32'(addr_v[0]), 32'h0);
        check("reset rd_data", data_v[0], 32'h0);

        // back-to-back non-loads, middle one targets x0
        valid = 1'b1; is_load = 1'b0; wr_rd = 1'b1; rd = 5'd1; result = 32'hA;
        @(negedge clk);
        check("x1 ce_wr", 32'(ce_v[0]), 32'd1);
        check("x1 addr", 32'(addr_v[0]), 32'd1);
        check("x1 data", data_v[0], 32'hA);
        rd = 5'd0; result = 32'hB;
        @(negedge clk);
        check("x0 suppressed", 32'(ce_v[0]), 32'd0);
        rd = 5'd5; result = 32'hC;
        @(negedge clk);
        check("x5 ce_wr", 32'(ce_v[0]), 32'd1);
        check("x5 addr", 32'(addr_v[0]), 32'd5);
        check("x5 data", data_v[0], 32'hC);
        valid = 1'b0; wr_rd = 1'b0;
        @(negedge clk);
        check("idle no write", 32'(ce_v[0]), 32'd0);

        do_load(3'b000, 2'd3, 32'hFFFFFF80);
        do_load(3'b100, 2'd1, 32'h0000007F);
        do_load(3'b001, 2'd2, 32'hFFFF80FF);
        do_load(3'b101, 2'd0, 32'h00007F01);
        do_load(3'b010, 2'd0, 32'h80FF7F01);

        // response 4 cycles after accept, with a non-load held on i_valid behind it
        valid = 1'b1; is_load = 1'b1; wr_rd = 1'b1; rd = 5'd3; f3 = 3'b010; lsb = 2'd0;
        @(negedge clk);
        is_load = 1'b0; rd = 5'd7; result = 32'h77;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("slow ready low k=%0d", k), 32'(ready_v[0]), 32'd0);
            if (k < 4) begin
                check($sformatf("t3 no timeout k=%0d", k), 32'(to_v[1]), 32'd0);
                @(negedge clk);
            end
        end
        check("t3 timeout pulse", 32'(to_v[1]), 32'd1);
        check("t3 no write at timeout", 32'(ce_v[1]), 32'd0);
        check("t3 ready at timeout", 32'(ready_v[1]), 32'd1);
        rdata_valid = 1'b1; rdata = 32'h80FF7F01;
        @(negedge clk);
        rdata_valid = 1'b0;
        check("slow ce_wr", 32'(ce_v[0]), 32'd1);
        check("slow data", data_v[0], 32'h80FF7F01);
        check("slow ready back", 32'(ready_v[0]), 32'd1);
        check("slow no timeout", 32'(to_v[0]), 32'd0);
        @(negedge clk);
        valid = 1'b0; wr_rd = 1'b0;
        check("held valid ce_wr", 32'(ce_v[0]), 32'd1);
        check("held valid addr", 32'(addr_v[0]), 32'd7);
        check("held valid data", data_v[0], 32'h77);
        @(negedge clk);

        // response at T+3 on the 3-cycle instance wins over the timeout
        valid = 1'b1; is_load = 1'b1; wr_rd = 1'b1; rd = 5'd9; f3 = 3'b100; lsb = 2'd2;
        @(negedge clk);
        valid = 1'b0; is_load = 1'b0;
        repeat (2) @(negedge clk);
        rdata_valid = 1'b1; rdata = 32'h80FF7F01;
        @(negedge clk);
        rdata_valid = 1'b0;
        check("t3 edge ce_wr", 32'(ce_v[1]), 32'd1);
        check("t3 edge data", data_v[1], 32'h000000FF);
        check("t3 edge no timeout", 32'(to_v[1]), 32'd0);

        // stray response in IDLE
        rdata_valid = 1'b1; rdata = 32'hDEADBEEF;
        @(negedge clk);
        rdata_valid = 1'b0;
        check("stray no write", 32'(ce_v), 32'd0);
        check("stray ready", 32'(ready_v), 32'h3);

        // no response: timeout on the short instance, then reset while the default one waits
        valid = 1'b1; is_load = 1'b1; wr_rd = 1'b1; rd = 5'd4; f3 = 3'b010; lsb = 2'd0;
        @(negedge clk);
        valid = 1'b0; is_load = 1'b0;
        repeat (3) @(negedge clk);
        check("lost load timeout", 32'(to_v[1]), 32'd1);
        check("lost load no write", 32'(ce_v[1]), 32'd0);
        check("dut0 still waiting", 32'(ready_v[0]), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rdata_valid = 1'b1; rdata = 32'h12345678;
        @(negedge clk);
        rdata_valid = 1'b0;
        check("post-reset no write", 32'(ce_v[0]), 32'd0);
        check("post-reset ready", 32'(ready_v[0]), 32'd1);
        check("post-reset addr", 32'(addr_v[0]), 32'd0);
        check("post-reset data", data_v[0], 32'd0);
        check("post-reset timeout", 32'(to_v[0]), 32'd0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/asrv32_writeback.md
# asrv32_writeback

Writeback stage of the ASRV32 core. It accepts one retiring instruction per handshake from the memory stage, waits for the data-memory response on loads, and aligns and extends the load data. It then drives the write port of the base register file (`asrv32_basereg`: `i_ce_wr`, `i_rd_addr`, `i_rd_data`) with a registered, single-cycle write pulse. It also back-pressures the memory stage while a load is outstanding and flags loads whose response never arrives.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: number of WAIT_LOAD cycles without a response before a load is abandoned. Legal range is 1 or greater.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge
- `i_rst_n`  in  1  reset; asynchronous assert, active-low
- `i_valid`  in  1  memory stage presents an instruction
- `o_ready`  out  1  writeback can accept; high only in IDLE
- `i_wr_rd`  in  1  instruction writes rd
- `i_rd_addr`  in  5  destination register
- `i_result`  in  32  ALU/CSR result for non-load instructions
- `i_is_load`  in  1  instruction is a load
- `i_funct3`  in  3  load type encoding
- `i_addr_lsb`  in  2  low bits of the load byte address
- `i_rdata_valid`  in  1  data-memory response strobe
- `i_rdata`  in  32  data-memory response word
- `o_ce_wr`  out  1  register-file write enable; one-cycle pulse
- `o_rd_addr`  out  5  register-file write address
- `o_rd_data`  out  32  register-file write data
- `o_load_timeout`  out  1  one-cycle pulse when a load is abandoned

## Operation
- **Handshake.** A transfer occurs when `i_valid && o_ready`. `o_ready` is combinational from state: 1 in IDLE, 0 in WAIT_LOAD.
- **FSM states and transitions:**
  - IDLE, accept, non-load: stay in IDLE. Next cycle `o_ce_wr = i_wr_rd && (i_rd_addr != 0)`, `o_rd_addr = i_rd_addr`, `o_rd_data = i_result`.
  - IDLE, accept, load: capture rd address, `i_wr_rd`, funct3 and lsb; clear the timeout counter; go to WAIT_LOAD.
  - WAIT_LOAD with `i_rdata_valid`: next cycle drive the formatted data with `o_ce_wr = wr_rd && rd != 0`; go to IDLE.
  - WAIT_LOAD without a response: the counter increments. When the counter equals `TIMEOUT_CYCLES-1`: pulse `o_load_timeout` next cycle, perform no write, go to IDLE.
- **Load formatting** (`i_rdata` little-endian):
  - funct3 000 (LB): byte at lsb, sign-extended.
  - 100 (LBU): byte at lsb, zero-extended.
  - 001 (LH): halfword selected by lsb[1], sign-extended.
  - 101 (LHU): halfword selected by lsb[1], zero-extended.
  - 010 (LW) and all other encodings: full word, lsb ignored.
  - Misalignment is checked upstream; lsb[0] is ignored for halfwords.
- **x0:** writes to x0 are suppressed here as well as in the register file.
- **Stray responses:** `i_rdata_valid` while in IDLE is ignored.
- **Counter width:** `$clog2(TIMEOUT_CYCLES+1)` bits. The counter saturates and never wraps.

## Timing
- **Reset values:** state IDLE, `o_ready` 1, `o_ce_wr` 0, `o_rd_addr` 0, `o_rd_data` 0, `o_load_timeout` 0, counter 0.
- **Non-load:** accepted at cycle T, write pulse at T+1. Back-to-back non-loads sustain one write per cycle.
- **Load:** accepted at T. The earliest response is T+1. A response at T+k gives the write pulse and `o_ready` = 1 at T+k+1.
- **Timeout:** a response never arriving produces `o_load_timeout` at T+TIMEOUT_CYCLES+1, with `o_ready` = 1 in that same cycle.
- **Simultaneous events:** a response in the same cycle the counter hits its limit wins. The data is written and no timeout is signalled.
- **Pulse width:** `o_ce_wr` and `o_load_timeout` are high for exactly one cycle and are never high together.
- **Reset mid-load:** the pending load is discarded with no write. After reset release, a response for the abandoned load arrives in IDLE and is ignored.

## Structure
- **Shared package `asrv32_pkg`:**
  - Load funct3 constants (`LB`, `LH`, `LW`, `LBU`, `LHU`).
  - The writeback state encoding (IDLE, WAIT_LOAD).
- **Sub-module `asrv32_load_align`:** combinational, takes rdata, funct3 and lsb, returns the 32-bit formatted value. It is reusable by a future forwarding path.

## Test plan
- Reset asserted mid-WAIT_LOAD, then response 0x12345678 after release. Required: no write, `o_ready` = 1, all outputs at reset values.
- Three back-to-back non-loads (x1 = 0xA, x0 = 0xB, x5 = 0xC). Required: writes to x1 and x5 on consecutive cycles; no `o_ce_wr` for x0.
- Loads with rdata 0x80FF7F01 into x3:
  - LB with lsb=3 gives 0xFFFFFF80.
  - LBU with lsb=1 gives 0x0000007F.
  - LH with lsb=2 gives 0xFFFF80FF.
  - LHU with lsb=0 gives 0x00007F01.
  - LW gives 0x80FF7F01.
- Load with the response 4 cycles after accept. Required: `o_ready` low for exactly 4 cycles; a write pulse one cycle after the response; an `i_valid` held high is accepted on the following cycle.
- `TIMEOUT_CYCLES` = 3 with no response. Required: `o_load_timeout` pulse at T+4 and no write. Separately, a response arriving at T+3 is written and no timeout is signalled.
- `i_rdata_valid` pulsed in IDLE with no pending load. Required: no write, state unchanged.
